ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Execute-stage multiply/divide unit, directly downstream of the ID/EX pipeline buffer.
- Consumes the buffered register operands and funct field, and owns the architectural HI/LO registers.
- Runs MULT/MULTU/DIV/DIVU iteratively.
- Raises busy so hazard logic stalls the front end.
- Serves MFHI/MFLO/MTHI/MTLO.

Parameters:
WIDTH, 32, operand/HI/LO width; only 32 is supported.
DIV0_LO, 32'hFFFF_FFFF, LO value written on divide-by-zero.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
op_valid  in  1  ID/EX holds an R-type instruction for this unit this cycle
funct_in  in  6  funct from ID/EX
rs_data  in  32  data_read1 from ID/EX
rt_data  in  32  data_read2 from ID/EX
flush  in  1  kill in-flight operation (branch/jump squash)
busy  out  1  operation in progress; upstream must hold
done  out  1  one-cycle pulse when HI/LO written by MULT/DIV
div_by_zero  out  1  sticky flag, set by DIV/DIVU with rt_data==0
result  out  32  registered MFHI/MFLO value for EX/MEM
hi  out  32  current HI
lo  out  32  current LO

Behaviour:
- Reset: all outputs 0, HI=LO=0, state IDLE.
  - Reset asserted mid-operation aborts immediately.
  - Reset does not clear anything else beyond the above.
- Funct codes:
  - MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B
  - Any other funct is ignored.
- States: IDLE, MUL, DIV, FIX.
- IDLE, op_valid=1, flush=0 (edge E0), by funct:
  - MTHI/MTLO: HI/LO <= rs_data at E0. No busy.
  - MFHI/MFLO: result <= HI/LO at E0, visible the following cycle. Uses the pre-edge HI/LO value.
  - MULT/MULTU: latch operands (absolute values for signed); record result sign; go to MUL.
  - DIV/DIVU, rt_data!=0: latch absolute dividend/divisor, quotient sign and remainder sign (remainder takes dividend sign); go to DIV.
  - DIV/DIVU, rt_data==0: set div_by_zero; preset LO=DIV0_LO, HI=rs_data; go to FIX with no sign fix.
- MUL:
  - Radix-2 shift-add, one multiplier bit per cycle, 32 cycles.
  - 64-bit accumulator.
  - Then FIX.
- DIV:
  - Restoring division, one quotient bit per cycle, 32 cycles.
  - 6-bit iteration counter, counts 0..31; wraps to FIX at 31.
- FIX:
  - Apply two's-complement sign correction: 64-bit for multiply, separate for quotient/remainder.
  - Write HI/LO.
  - done=1 for the next cycle; return to IDLE.
- busy=1 in every cycle where state != IDLE.
  - Nominal MULT/DIV: 33 busy cycles.
  - Divide-by-zero: 1 busy cycle.
- op_valid while busy is ignored; hazard unit guarantees it is held.
- flush:
  - In MUL/DIV/FIX: abort, no HI/LO write, no done, IDLE next cycle.
  - In IDLE with op_valid: flush wins and the op is discarded, including MT*/MF*.
- div_by_zero clears only on rst or on the next accepted DIV/DIVU with a nonzero divisor.
- Signed edge cases:
  - 0x80000000 × any: handled by 64-bit magnitude.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrapped).

Optional Feature:
MULDIV_EARLY_TERM_EN
- Defined: MUL leaves for FIX as soon as the remaining multiplier bits are all zero, evaluated each cycle including the first.
  - Minimum MUL occupancy: 1 cycle. busy length is data-dependent.
  - Results are identical to the non-early-terminated path.
- Undefined: fixed 32-cycle MUL.
- DIV is unaffected either way.

Decomposition:
- Package muldiv_pkg: funct constants, state enum, WIDTH/counter-width constants.
- Sub-module muldiv_datapath: 64-bit accumulator/remainder shift registers, add/subtract, sign correction.
- The top level holds the FSM, HI/LO, result and flags.

Test Plan:
- MULT rs=0xFFFFFFFD rt=7 -> busy 33 cycles, done pulse, HI=0xFFFFFFFF LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF×0xFFFFFFFF -> HI=0xFFFFFFFE LO=0x00000001; with MULDIV_EARLY_TERM_EN, MULTU 5×3 -> busy ≤4 cycles, LO=0xF HI=0.
- DIV rs=0xFFFFFFF9 rt=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU 7/2 -> LO=3 HI=1.
- DIVU rs=0x1234 rt=0 -> busy 1 cycle, LO=0xFFFFFFFF HI=0x1234, div_by_zero=1; next DIVU 8/2 clears it.
- MTHI 0xAAAA5555, MTLO 0x5555AAAA, MULT then flush at busy cycle 10 -> busy low next cycle, no done, HI/LO unchanged; MFHI -> result 0xAAAA5555.
- rst asserted mid-DIV, asynchronously between edges -> busy/hi/lo/result/flags read 0 immediately; state IDLE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: funct codes, FSM state codes and widths shared by the EX multiply/divide unit.
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_ITER = 6'd31;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MTHI = 6'h11;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV = 6'h1A;
  localparam logic [5:0] F_DIVU = 6'h1B;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL = 2'd1;
  localparam logic [1:0] S_DIV = 2'd2;
  localparam logic [1:0] S_FIX = 2'd3;
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiplier / restoring divider registers and final sign correction.
// With MULDIV_EARLY_TERM_EN, mul_stop flags that no multiplier bits remain after this step.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter logic [XLEN-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            start,
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            step_mul,
  input  logic            step_div,
  output logic            mul_stop,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo
);
  logic [63:0] acc, mcand, prod;
  logic [31:0] mplier;
  logic [32:0] diff;
  logic neg_lo, neg_hi, is_mul, mul_op, sgn, sa, sb, dz;
  always_comb begin
    mul_op = funct == F_MULT || funct == F_MULTU;
    sgn = funct == F_MULT || funct == F_DIV;
    sa = sgn & a[31];
    sb = sgn & b[31];
    dz = !mul_op && b == '0;
    diff = acc[63:31] - {1'b0, mcand[31:0]};
    prod = neg_lo ? -acc : acc;
    res_hi = is_mul ? prod[63:32] : mag(acc[63:32], neg_hi);
    res_lo = is_mul ? prod[31:0] : mag(acc[31:0], neg_lo);
  end
`ifdef MULDIV_EARLY_TERM_EN
  assign mul_stop = mplier[31:1] == '0;
`else
  assign mul_stop = 1'b0;
`endif
  // Divide: acc = {remainder, quotient}; multiply: acc accumulates the 64-bit magnitude.
  always_ff @(posedge clk) begin
    if (start) begin
      is_mul <= mul_op;
      neg_lo <= !dz & (sa ^ sb);
      neg_hi <= !dz & (mul_op ? sa ^ sb : sa);
      mcand <= {32'b0, mul_op ? mag(a, sa) : mag(b, sb)};
      mplier <= mag(b, sb);
      acc <= mul_op ? 64'b0 : dz ? {a, DIV0_LO} : {32'b0, mag(a, sa)};
    end else if (step_mul) begin
      acc <= acc + (mplier[0] ? mcand : 64'b0);
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (step_div) begin
      acc <= diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
    end
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: EX-stage iterative MULT/DIV with HI/LO, MFHI/MFLO/MTHI/MTLO and stall control.
// Optional MULDIV_EARLY_TERM_EN ends MUL once the remaining multiplier bits are zero.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [5:0]       funct_in,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic accept, is_mul_f, is_div_f, mul_stop;
  logic [WIDTH-1:0] res_hi, res_lo;
  assign accept = state == S_IDLE && op_valid && !flush;
  assign is_mul_f = funct_in == F_MULT || funct_in == F_MULTU;
  assign is_div_f = funct_in == F_DIV || funct_in == F_DIVU;
  assign busy = state != S_IDLE;
  muldiv_datapath #(.DIV0_LO(DIV0_LO)) u_dp (
    .clk(clk),
    .start(accept && (is_mul_f || is_div_f)),
    .funct(funct_in),
    .a(rs_data),
    .b(rt_data),
    .step_mul(state == S_MUL),
    .step_div(state == S_DIV),
    .mul_stop(mul_stop),
    .res_hi(res_hi),
    .res_lo(res_lo)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      result <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (funct_in == F_MTHI) hi <= rs_data;
          if (funct_in == F_MTLO) lo <= rs_data;
          if (funct_in == F_MFHI) result <= hi;
          if (funct_in == F_MFLO) result <= lo;
          if (is_mul_f) state <= S_MUL;
          if (is_div_f) begin
            div_by_zero <= rt_data == '0;
            state <= rt_data == '0 ? S_FIX : S_DIV;
          end
          cnt <= '0;
        end
        S_MUL: begin
          state <= flush ? S_IDLE : (mul_stop || cnt == LAST_ITER) ? S_FIX : S_MUL;
          cnt <= cnt + 1'b1;
        end
        S_DIV: begin
          state <= flush ? S_IDLE : cnt == LAST_ITER ? S_FIX : S_DIV;
          cnt <= cnt + 1'b1;
        end
        default: begin
          state <= S_IDLE;
          if (!flush) begin
            hi <= res_hi;
            lo <= res_lo;
            done <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: random and directed stimulus checked every cycle against a behavioural model.
module tb_ex_muldiv_unit;
  localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
  localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;
  logic clk = 0, rst = 1, op_valid = 0, flush = 0;
  logic [5:0] funct_in = 0;
  logic [31:0] rs_data = 0, rt_data = 0;
  logic busy, done, div_by_zero;
  logic [31:0] result, hi, lo;
  logic [31:0] m_hi, m_lo, m_res, p_hi, p_lo;
  logic m_dbz, m_done;
  int m_left;
  int checks = 0, failures = 0;
  int bc, dn;
  ex_muldiv_unit dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .funct_in(funct_in),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .busy(busy),
    .done(done), .div_by_zero(div_by_zero), .result(result), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    m_hi = 0; m_lo = 0; m_res = 0; m_dbz = 0; m_done = 0; m_left = 0;
  endtask
  function automatic int mul_len(input logic [31:0] m);
    int n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
`ifndef MULDIV_EARLY_TERM_EN
    n = 32;
`endif
    return n + 1;
  endfunction
  task automatic model_edge();
    logic [63:0] p;
    longint sa, sb;
    m_done = 0;
    if (m_left > 0) begin
      if (flush) m_left = 0;
      else begin
        m_left--;
        if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1; end
      end
    end else if (op_valid && !flush) begin
      case (funct_in)
        MFHI: m_res = m_hi;
        MFLO: m_res = m_lo;
        MTHI: m_hi = rs_data;
        MTLO: m_lo = rs_data;
        MULT: begin
          p = 64'(longint'($signed(rs_data)) * longint'($signed(rt_data)));
          {p_hi, p_lo} = p;
          m_left = mul_len(rt_data[31] ? -rt_data : rt_data);
        end
        MULTU: begin
          p = {32'b0, rs_data} * {32'b0, rt_data};
          {p_hi, p_lo} = p;
          m_left = mul_len(rt_data);
        end
        DIV, DIVU: begin
          if (rt_data == 0) begin
            m_dbz = 1; p_hi = rs_data; p_lo = 32'hFFFF_FFFF; m_left = 1;
          end else begin
            m_dbz = 0; m_left = 33;
            if (funct_in == DIV) begin
              sa = longint'($signed(rs_data));
              sb = longint'($signed(rt_data));
              p_lo = 32'(sa / sb);
              p_hi = 32'(sa % sb);
            end else begin
              p_lo = rs_data / rt_data;
              p_hi = rs_data % rt_data;
            end
          end
        end
        default: ;
      endcase
    end
  endtask
  task automatic compare();
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("done", 32'(done), 32'(m_done));
    chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("result", result, m_res);
  endtask
  task automatic cycle(input logic v, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input logic fl);
    op_valid = v; funct_in = f; rs_data = a; rt_data = b; flush = fl;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, output int nb, output int nd);
    cycle(1, f, a, b, 0);
    nb = 0; nd = 0;
    repeat (36) begin
      nb += int'(busy);
      nd += int'(done);
      cycle(0, 6'h0, 0, 0, 0);
    end
  endtask
  function automatic logic [31:0] rv();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [5:0] fl [9];
    logic [5:0] f;
    logic [31:0] a, b;
    fl = '{MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU, 6'h2A};
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    rst = 0;
    run_op(MULT, 32'hFFFF_FFFD, 7, bc, dn);
    chk("mult_busy_cycles", bc, 33);
    chk("mult_done_pulses", dn, 1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, dn);
    chk("multu_busy_cycles", bc, 33);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    run_op(MULTU, 5, 3, bc, dn);
`ifdef MULDIV_EARLY_TERM_EN
    chk("multu_early_busy_le4", 32'(bc <= 4), 1);
`else
    chk("multu_small_busy", bc, 33);
`endif
    chk("multu_small_lo", lo, 32'hF);
    chk("multu_small_hi", hi, 0);
    run_op(DIV, 32'hFFFF_FFF9, 2, bc, dn);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run_op(DIVU, 7, 2, bc, dn);
    chk("divu_lo", lo, 3);
    chk("divu_hi", hi, 1);
    run_op(DIVU, 32'h1234, 0, bc, dn);
    chk("div0_busy_cycles", bc, 1);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'h1234);
    chk("div0_flag", 32'(div_by_zero), 1);
    run_op(DIVU, 8, 2, bc, dn);
    chk("div0_flag_cleared", 32'(div_by_zero), 0);
    chk("divu8_lo", lo, 4);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, dn);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 0);
    cycle(1, MTHI, 32'hAAAA_5555, 0, 0);
    cycle(1, MTLO, 32'h5555_AAAA, 0, 0);
    cycle(1, MULT, 32'h0123_4567, 32'h89AB, 0);
    repeat (9) cycle(0, 6'h0, 0, 0, 0);
    cycle(0, 6'h0, 0, 0, 1);
    chk("flush_busy_low", 32'(busy), 0);
    dn = 0;
    repeat (5) begin dn += int'(done); cycle(0, 6'h0, 0, 0, 0); end
    chk("flush_no_done", dn, 0);
    chk("flush_hi_kept", hi, 32'hAAAA_5555);
    chk("flush_lo_kept", lo, 32'h5555_AAAA);
    cycle(1, MFHI, 0, 0, 0);
    chk("mfhi_result", result, 32'hAAAA_5555);
    cycle(1, MTHI, 32'h1234_5678, 0, 1);
    chk("idle_flush_discard", hi, 32'hAAAA_5555);
    repeat (150) begin
      f = fl[$urandom_range(0, 8)];
      a = rv();
      b = rv();
      if ((f == DIV || f == DIVU) && $urandom_range(0, 5) == 0) b = 0;
      cycle(1, f, a, b, $urandom_range(0, 11) == 0);
      while (m_left > 0)
        cycle(1'($urandom), 6'($urandom), 32'($urandom), 32'($urandom), $urandom_range(0, 39) == 0);
    end
    run_op(DIVU, 32'h55, 0, bc, dn);
    cycle(1, MFHI, 0, 0, 0);
    cycle(1, DIV, 32'h100, 7, 0);
    repeat (4) cycle(0, 6'h0, 0, 0, 0);
    #2 rst = 1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_dbz", 32'(div_by_zero), 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_result", result, 0);
    model_reset();
    @(negedge clk);
    compare();
    rst = 0;
    run_op(DIVU, 9, 2, bc, dn);
    chk("post_rst_divu_lo", lo, 4);
    chk("post_rst_divu_hi", hi, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
